// File: rtl/sscfifo_pkg.sv
// Shared constants and width helpers for the sscfifo_thr FIFO family.
package sscfifo_pkg;

    localparam int FWFT_STD = 0;
    localparam int FWFT_ON  = 1;

    localparam logic RST_DATA_BIT = 1'b0;

    function automatic int clamp_min1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    // Pointers and occupancy need one extra bit to tell full from empty.
    function automatic int cnt_width(input int depth_width);
        return clamp_min1(depth_width) + 1;
    endfunction

endpackage

// File: rtl/simple_dpram_sclk.sv
// Simple dual-port single-clock RAM with registered read and optional write-to-read bypass.
module simple_dpram_sclk #(
    parameter int ADDR_WIDTH    = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int ENABLE_BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= din;
        end
    end

    // Bypass returns the word being written when both ports hit the same address.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
        end else if (re) begin
            if ((ENABLE_BYPASS != 0) && we && (waddr == raddr)) begin
                dout <= din;
            end else begin
                dout <= mem[raddr];
            end
        end
    end

endmodule

// File: rtl/sscfifo_fwft_stage.sv
// First-word-fall-through head stage: tracks the word in flight out of the RAM and the presented head word.
module sscfifo_fwft_stage
    import sscfifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ram_avail,
    input  logic [DATA_WIDTH-1:0] ram_data,
    input  logic                  pop,
    output logic                  ram_re,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid
);

    logic mid_vld;
    logic mid_mv;

    // The RAM read register acts as a one-word skid slot ahead of the head register.
    assign mid_mv = mid_vld & (~valid | pop);
    assign ram_re = ram_avail & (~mid_vld | mid_mv);

    always_ff @(posedge clk) begin
        if (rst) begin
            mid_vld <= 1'b0;
            valid   <= 1'b0;
            data    <= {DATA_WIDTH{RST_DATA_BIT}};
        end else begin
            mid_vld <= ram_re | (mid_vld & ~mid_mv);
            if (mid_mv) begin
                valid <= 1'b1;
                data  <= ram_data;
            end else if (pop) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sscfifo_thr.sv
// Single-clock FIFO with occupancy, programmable nearly-full/empty thresholds and optional FWFT read.
// Define SSCFIFO_ERR_STICKY_EN to build the sticky overflow/underflow error flags.
module sscfifo_thr
    import sscfifo_pkg::*;
#(
    parameter int DEPTH_WIDTH = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int FWFT        = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [clamp_min1(DATA_WIDTH)-1:0]    wr_data_i,
    input  logic                                 wr_en_i,
    input  logic                                 rd_en_i,
    output logic [clamp_min1(DATA_WIDTH)-1:0]    rd_data_o,
    input  logic [cnt_width(DEPTH_WIDTH)-1:0]    af_thr_i,
    input  logic [cnt_width(DEPTH_WIDTH)-1:0]    ae_thr_i,
    output logic [cnt_width(DEPTH_WIDTH)-1:0]    count_o,
    output logic                                 full_o,
    output logic                                 empty_o,
    output logic                                 nearly_full_o,
    output logic                                 nearly_empty_o,
    output logic                                 overflow_o,
    output logic                                 underflow_o,
    input  logic                                 clr_err_i
);

    localparam int DW  = clamp_min1(DEPTH_WIDTH);
    localparam int DAT = clamp_min1(DATA_WIDTH);
    localparam int CW  = DW + 1;
    localparam logic [CW-1:0] CAP = CW'(1) << DW;

    if (DEPTH_WIDTH < 1) begin : g_dw_warn
        $warning("sscfifo_thr: DEPTH_WIDTH below 1, clamped to 1");
    end
    if (DATA_WIDTH < 1) begin : g_data_warn
        $warning("sscfifo_thr: DATA_WIDTH below 1, clamped to 1");
    end
    if ((FWFT != FWFT_STD) && (FWFT != FWFT_ON)) begin : g_fwft_warn
        $warning("sscfifo_thr: FWFT not 0 or 1, treated as standard read");
    end

    logic [CW-1:0]  wr_ptr;
    logic [CW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           wr_acc;
    logic           rd_acc;
    logic           ram_re;
    logic [DAT-1:0] ram_dout;

    assign full_o         = (count == CAP);
    assign wr_acc         = wr_en_i & ~full_o;
    assign rd_acc         = rd_en_i & ~empty_o;
    assign count_o        = count;
    assign nearly_full_o  = (count >= af_thr_i);
    assign nearly_empty_o = (count <= ae_thr_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + CW'(1);
            end
            // rd_ptr tracks RAM reads, which lead pops in FWFT mode.
            if (ram_re) begin
                rd_ptr <= rd_ptr + CW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    simple_dpram_sclk #(
        .ADDR_WIDTH    (DW),
        .DATA_WIDTH    (DAT),
        .ENABLE_BYPASS (1)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .raddr (rd_ptr[DW-1:0]),
        .re    (ram_re),
        .waddr (wr_ptr[DW-1:0]),
        .we    (wr_acc),
        .din   (wr_data_i),
        .dout  (ram_dout)
    );

    if (FWFT == FWFT_ON) begin : g_fwft
        logic ram_avail;
        logic head_vld;

        // A write into an otherwise drained RAM is fetched the same cycle through the bypass.
        assign ram_avail = (wr_ptr != rd_ptr) | wr_acc;
        assign empty_o   = ~head_vld;

        sscfifo_fwft_stage #(
            .DATA_WIDTH (DAT)
        ) u_fwft (
            .clk       (clk),
            .rst       (rst),
            .ram_avail (ram_avail),
            .ram_data  (ram_dout),
            .pop       (rd_acc),
            .ram_re    (ram_re),
            .data      (rd_data_o),
            .valid     (head_vld)
        );
    end else begin : g_std
        assign ram_re    = rd_acc;
        assign rd_data_o = ram_dout;
        assign empty_o   = (count == '0);
    end

`ifdef SSCFIFO_ERR_STICKY_EN
    logic ovf;
    logic udf;

    // A new error event outranks a coincident clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (wr_en_i & full_o) begin
                ovf <= 1'b1;
            end else if (clr_err_i) begin
                ovf <= 1'b0;
            end
            if (rd_en_i & empty_o) begin
                udf <= 1'b1;
            end else if (clr_err_i) begin
                udf <= 1'b0;
            end
        end
    end

    assign overflow_o  = ovf;
    assign underflow_o = udf;
`else
    logic unused_clr_err;

    assign unused_clr_err = clr_err_i;
    assign overflow_o     = 1'b0;
    assign underflow_o    = 1'b0;
`endif

endmodule

// File: doc/sscfifo_thr.md
Name: sscfifo_thr

Overview:
- Next-generation single-clock synchronous FIFO for the GPU command and pixel paths. Parametrised in width and depth.
- Adds over the previous FIFO generation:
  - write/read protection at the full/empty boundaries;
  - exact occupancy output;
  - runtime-programmable nearly-full and nearly-empty thresholds;
  - an optional first-word-fall-through (FWFT) read mode.
- Storage is the shared simple dual-port single-clock RAM with bypass enabled.

Parameters:
- DEPTH_WIDTH, 4, log2 of capacity; minimum 1 (values below 1 are clamped to 1, with a simulation warning).
- DATA_WIDTH, 32, word width; minimum 1 (same clamping).
- FWFT, 0, 0 = standard read (data one cycle after rd_en_i); 1 = head word presented whenever !empty_o.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_data_i  in  DATA_WIDTH  write data.
- wr_en_i  in  1  write request.
- rd_en_i  in  1  read request; in FWFT mode, acknowledges/pops the head word.
- rd_data_o  out  DATA_WIDTH  read data.
- af_thr_i  in  DEPTH_WIDTH+1  nearly-full threshold.
- ae_thr_i  in  DEPTH_WIDTH+1  nearly-empty threshold.
- count_o  out  DEPTH_WIDTH+1  occupancy, 0..2**DEPTH_WIDTH.
- full_o  out  1  count_o == 2**DEPTH_WIDTH.
- empty_o  out  1  no readable word.
- nearly_full_o  out  1  count_o >= af_thr_i.
- nearly_empty_o  out  1  count_o <= ae_thr_i.
- overflow_o  out  1  sticky: write attempted while full.
- underflow_o  out  1  sticky: read attempted while empty.
- clr_err_i  in  1  clears overflow_o and underflow_o.

Behaviour:
- Accept rules: wr_acc = wr_en_i & ~full_o; rd_acc = rd_en_i & ~empty_o. Both use the current-cycle flags.
  - Pointers advance only on an accepted operation. A rejected request has no effect on state other than the error flags.
- Pointers are DEPTH_WIDTH+1 bits and wrap modulo 2**(DEPTH_WIDTH+1). The RAM address is the low DEPTH_WIDTH bits.
- Occupancy counter: +1 on wr_acc & ~rd_acc; -1 on rd_acc & ~wr_acc; otherwise held. count_o is the register output.
- Simultaneous read and write:
  - When full: only the read is accepted; count drops by 1 and full_o deasserts next cycle.
  - When empty: only the write is accepted.
  - Otherwise: both are accepted and count is unchanged.
- Flags are combinational from registered state, with no output latency of their own.
- Threshold inputs are sampled continuously; a change takes effect in the same cycle.
- FWFT=0 timing:
  - rd_data_o is updated at the edge after rd_acc and held otherwise.
  - A write at cycle N makes empty_o fall at N+1.
  - A read at N+1 yields that word at N+2.
- FWFT=1 timing:
  - Internal one-word output register plus valid bit. empty_o = ~valid.
  - count_o includes the output-register word. Total capacity is still 2**DEPTH_WIDTH.
  - The output register refills from RAM whenever it is empty or being popped and RAM holds data.
  - A write into an empty FIFO at cycle N makes empty_o fall at N+2, with rd_data_o already showing the word.
  - Back-to-back pops with RAM non-empty sustain 1 word per cycle.
- Reset values: pointers 0, count_o 0, empty_o 1, full_o 0, nearly_empty_o 1, nearly_full_o = (af_thr_i == 0), rd_data_o 0, valid 0, overflow_o 0, underflow_o 0.
- Reset mid-operation discards all contents. Requests presented in the reset cycle are ignored.
- af_thr_i > 2**DEPTH_WIDTH means nearly_full_o never asserts. This is legal and not an error.

Optional Feature:
- Macro: SSCFIFO_ERR_STICKY_EN.
- Defined:
  - overflow_o sets on wr_en_i & full_o; underflow_o sets on rd_en_i & empty_o.
  - Both hold until clr_err_i or rst.
  - If clr_err_i coincides with a new error event, the set wins.
- Undefined:
  - overflow_o and underflow_o are tied to 0 and clr_err_i is ignored.
  - No error registers are synthesised.

Decomposition:
- Package sscfifo_pkg holds the count/pointer width helper function, the FWFT mode constants, and the reset data value.
- One natural sub-module, sscfifo_fwft_stage: the output register, valid bit, refill logic and pop handling. It is instantiated only when FWFT=1.
- RAM is the existing simple_dpram_sclk with ENABLE_BYPASS=1.

Test Plan:
- DEPTH_WIDTH=2, FWFT=0. Write 4 words A..D with no reads → full_o=1 and count_o=4. A 5th write of E is rejected. Reads return A,B,C,D and empty_o=1 after the 4th read. overflow_o=1 when the macro is on.
- Full FIFO with wr_en_i=rd_en_i=1 for 1 cycle → head word read, count_o goes 4→3, write dropped. Next cycle the simultaneous pair is accepted and count_o stays 3.
- Empty FIFO with wr_en_i=rd_en_i=1 → count_o 0→1, rd_data_o unchanged, underflow_o=1 with the macro on and 0 with it off.
- af_thr_i=3, ae_thr_i=1. Fill 0→4: nearly_empty_o is 1 at counts 0–1; nearly_full_o asserts at count 3. Changing af_thr_i to 5 deasserts nearly_full_o in the same cycle.
- FWFT=1. Write X at cycle N → empty_o falls and rd_data_o=X at N+2. Streaming 16 words with continuous pops → 1 word per cycle, in order, no gaps.
- Pointer wrap: DEPTH_WIDTH=2, 100 random accepted operations checked against a reference model. Then rst asserted while count_o=3 → next cycle count_o=0, empty_o=1, rd_data_o=0.
